// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the shared line-wide memory bus (port 0 I-cache miss, port 1 D-cache fill/writeback).
// Every output is registered; a watchdog aborts memory transactions that never see mem_ready.
module mem_bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int WORDS   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [1:0]                   req_read,
    input  logic [1:0]                   req_write,
    input  logic [1:0][XLEN-1:0]         req_address,
    input  logic [1:0][WORDS*XLEN-1:0]   req_wdata,
    output logic [1:0]                   done,
    output logic                         error,
    output logic [WORDS*XLEN-1:0]        rdata,
    output logic                         grant_id,
    output logic                         busy,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [XLEN-1:0]              mem_address,
    output logic [WORDS*XLEN-1:0]        mem_wdata,
    input  logic [WORDS*XLEN-1:0]        mem_rdata,
    input  logic                         mem_ready
);

    localparam int LW = WORDS * XLEN;
    localparam int AB = $clog2(WORDS) + 2;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [XLEN-1:0] ADDR_MASK = {XLEN{1'b1}} << AB;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state, w_state_n;
    logic            r_last_grant, w_last_grant_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic            r_grant_id, w_grant_id_n;
    logic [1:0]      r_done, w_done_n;
    logic            r_error, w_error_n;
    logic [LW-1:0]   r_rdata, w_rdata_n;
    logic            r_busy, w_busy_n;
    logic            r_mem_read, w_mem_read_n;
    logic            r_mem_write, w_mem_write_n;
    logic [XLEN-1:0] r_mem_address, w_mem_address_n;
    logic [LW-1:0]   r_mem_wdata, w_mem_wdata_n;

    logic [1:0]      w_req;
    logic            w_winner;

    assign w_req = req_read | req_write;
    // Tie goes to the port that did not win last; otherwise the lone requester.
    assign w_winner = (&w_req) ? ~r_last_grant : w_req[1];

    always_comb begin
        w_state_n       = r_state;
        w_last_grant_n  = r_last_grant;
        w_cnt_n         = r_cnt;
        w_grant_id_n    = r_grant_id;
        w_done_n        = '0;
        w_error_n       = 1'b0;
        w_rdata_n       = r_rdata;
        w_busy_n        = r_busy;
        w_mem_read_n    = r_mem_read;
        w_mem_write_n   = r_mem_write;
        w_mem_address_n = r_mem_address;
        w_mem_wdata_n   = r_mem_wdata;

        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_state_n       = S_BUSY;
                    w_grant_id_n    = w_winner;
                    w_mem_write_n   = req_write[w_winner];
                    w_mem_read_n    = ~req_write[w_winner];
                    w_mem_address_n = req_address[w_winner] & ADDR_MASK;
                    w_mem_wdata_n   = req_wdata[w_winner];
                    w_busy_n        = 1'b1;
                    w_cnt_n         = '0;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    if (r_mem_read) begin
                        w_rdata_n = mem_rdata;
                    end
                    w_mem_read_n         = 1'b0;
                    w_mem_write_n        = 1'b0;
                    w_done_n[r_grant_id] = 1'b1;
                    w_state_n            = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_mem_read_n         = 1'b0;
                    w_mem_write_n        = 1'b0;
                    w_done_n[r_grant_id] = 1'b1;
                    w_error_n            = 1'b1;
                    w_state_n            = S_DONE;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_last_grant_n  = r_grant_id;
                w_busy_n        = 1'b0;
                w_mem_address_n = '0;
                w_mem_wdata_n   = '0;
                w_state_n       = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_cnt         <= '0;
            r_grant_id    <= 1'b0;
            r_done        <= '0;
            r_error       <= 1'b0;
            r_rdata       <= '0;
            r_busy        <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_state       <= w_state_n;
            r_last_grant  <= w_last_grant_n;
            r_cnt         <= w_cnt_n;
            r_grant_id    <= w_grant_id_n;
            r_done        <= w_done_n;
            r_error       <= w_error_n;
            r_rdata       <= w_rdata_n;
            r_busy        <= w_busy_n;
            r_mem_read    <= w_mem_read_n;
            r_mem_write   <= w_mem_write_n;
            r_mem_address <= w_mem_address_n;
            r_mem_wdata   <= w_mem_wdata_n;
        end
    end

    assign done        = r_done;
    assign error       = r_error;
    assign rdata       = r_rdata;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, read, tie round-robin, write precedence, timeout, reset mid-BUSY, stuck request.
module tb_mem_bus_arbiter;

    localparam int XLEN    = 32;
    localparam int WORDS   = 4;
    localparam int TIMEOUT = 8;
    localparam int LW      = WORDS * XLEN;

    localparam logic [LW-1:0] LINE1 = 128'h1111_2222_3333_4444_5555_6666_DEAD_BEEF;
    localparam logic [LW-1:0] LA    = 128'hA0A0_0001_A0A0_0002_A0A0_0003_A0A0_0004;
    localparam logic [LW-1:0] LB    = 128'hB0B0_0001_B0B0_0002_B0B0_0003_B0B0_0004;
    localparam logic [LW-1:0] LC    = 128'hC0C0_0001_C0C0_0002_C0C0_0003_C0C0_0004;
    localparam logic [LW-1:0] LJUNK = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    localparam logic [LW-1:0] PAT   = {16{8'hA5}};

    logic                   clock = 1'b0;
    logic                   reset;
    logic [1:0]             req_read, req_write;
    logic [1:0][XLEN-1:0]   req_address;
    logic [1:0][LW-1:0]     req_wdata;
    logic [1:0]             done;
    logic                   error;
    logic [LW-1:0]          rdata;
    logic                   grant_id, busy, mem_read, mem_write;
    logic [XLEN-1:0]        mem_address;
    logic [LW-1:0]          mem_wdata;
    logic [LW-1:0]          mem_rdata;
    logic                   mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_bus_arbiter #(.XLEN(XLEN), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) u_dut (
        .clock(clock), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .done(done), .error(error), .rdata(rdata),
        .grant_id(grant_id), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_read  = '0;
        req_write = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_strobe(input string tag);
        int k;
        k = 0;
        while (!(mem_read || mem_write) && k < 10) begin
            tick();
            k++;
        end
        check({tag, " strobe"}, LW'(mem_read | mem_write), LW'(1));
    endtask

    // Holds mem_ready low for 'delay' cycles, then presents the line for one edge.
    task automatic respond(input int delay, input logic [LW-1:0] line);
        repeat (delay) tick();
        mem_ready = 1'b1;
        mem_rdata = line;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] seen;
        logic [2:0] order;
        int         n;

        mem_rdata   = '0;
        req_address = '0;
        req_wdata   = '0;
        do_reset();
        check("rst ctl", LW'({busy, done, error, mem_read, mem_write, grant_id}), LW'(0));
        check("rst rdata", rdata, LW'(0));
        check("rst addr", LW'(mem_address), LW'(0));

        // Single read on port 0
        req_address[0] = 32'h0000_1234;
        req_read = 2'b01;
        tick();
        check("t1 rd", LW'(mem_read), LW'(1));
        check("t1 wr", LW'(mem_write), LW'(0));
        check("t1 addr", LW'(mem_address), LW'(32'h0000_1230));
        check("t1 gnt", LW'(grant_id), LW'(0));
        check("t1 busy", LW'(busy), LW'(1));
        check("t1 early done", LW'(done), LW'(0));
        respond(1, LINE1);
        check("t1 done", LW'(done), LW'(2'b01));
        check("t1 rdata", rdata, LINE1);
        check("t1 err", LW'(error), LW'(0));
        check("t1 strobe drop", LW'(mem_read), LW'(0));
        check("t1 busy held", LW'(busy), LW'(1));
        req_read = '0;
        tick();
        check("t1 done pulse", LW'(done), LW'(0));
        check("t1 busy fall", LW'(busy), LW'(0));
        check("t1 addr clr", LW'(mem_address), LW'(0));

        // Two ties after reset: port 0 then port 1, twice
        do_reset();
        req_address[0] = 32'h0000_0100;
        req_address[1] = 32'h0000_0208;
        for (int r = 0; r < 2; r++) begin
            req_read = 2'b11;
            tick();
            check("t2 gnt first", LW'(grant_id), LW'(0));
            check("t2 addr first", LW'(mem_address), LW'(32'h0000_0100));
            respond(0, LA);
            check("t2 done first", LW'(done), LW'(2'b01));
            check("t2 rdata first", rdata, LA);
            req_read = 2'b10;
            tick();
            check("t2 no reaccept", LW'(busy), LW'(0));
            tick();
            check("t2 gnt second", LW'(grant_id), LW'(1));
            check("t2 addr second", LW'(mem_address), LW'(32'h0000_0200));
            respond(0, LB);
            check("t2 done second", LW'(done), LW'(2'b10));
            check("t2 rdata second", rdata, LB);
            req_read = '0;
            tick();
        end

        // Write wins over read on the same port
        req_read          = 2'b10;
        req_write         = 2'b10;
        req_address[1]    = 32'h0000_0080;
        req_wdata[1]      = PAT;
        tick();
        check("t3 wr", LW'(mem_write), LW'(1));
        check("t3 rd", LW'(mem_read), LW'(0));
        check("t3 wdata", mem_wdata, PAT);
        check("t3 addr", LW'(mem_address), LW'(32'h0000_0080));
        check("t3 gnt", LW'(grant_id), LW'(1));
        respond(1, LJUNK);
        check("t3 done", LW'(done), LW'(2'b10));
        check("t3 rdata kept", rdata, LB);
        req_read  = '0;
        req_write = '0;
        tick();
        check("t3 wdata clr", mem_wdata, LW'(0));

        // Timeout with port 1 pending behind it
        req_read = 2'b11;
        tick();
        check("t4 gnt", LW'(grant_id), LW'(0));
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (done != 2'b00) break;
            if (mem_read) n++;
            tick();
        end
        check("t4 strobe cycles", LW'(n), LW'(TIMEOUT));
        check("t4 done", LW'(done), LW'(2'b01));
        check("t4 err", LW'(error), LW'(1));
        check("t4 rdata kept", rdata, LB);
        check("t4 strobe drop", LW'(mem_read), LW'(0));
        req_read = 2'b10;
        tick();
        check("t4 err clr", LW'({done, error}), LW'(0));
        tick();
        check("t4 next gnt", LW'(grant_id), LW'(1));
        check("t4 next rd", LW'(mem_read), LW'(1));
        respond(0, LC);
        check("t4 next done", LW'({done, error}), LW'({2'b10, 1'b0}));
        check("t4 next rdata", rdata, LC);
        req_read = '0;
        tick();

        // Reset mid-BUSY restores port 0 priority
        req_read = 2'b01;
        tick();
        respond(0, LA);
        check("t5 pre done", LW'(done), LW'(2'b01));
        req_read = '0;
        tick();
        req_read = 2'b10;
        tick();
        check("t5 gnt", LW'(grant_id), LW'(1));
        tick();
        reset = 1'b1;
        tick();
        check("t5 strobe drop", LW'(mem_read), LW'(0));
        check("t5 busy", LW'(busy), LW'(0));
        reset    = 1'b0;
        req_read = '0;
        seen     = done;
        repeat (3) begin
            tick();
            seen = seen | done;
        end
        check("t5 no done", LW'(seen), LW'(0));
        req_read = 2'b11;
        tick();
        check("t5 tie gnt", LW'(grant_id), LW'(0));
        check("t5 tie addr", LW'(mem_address), LW'(32'h0000_0100));

        // Stuck request on port 0, single request on port 1
        do_reset();
        req_read = 2'b11;
        order    = '0;
        for (int k = 0; k < 3; k++) begin
            wait_strobe("t6");
            order[2-k] = grant_id;
            respond(0, LA);
            check("t6 done", LW'(done), LW'(grant_id ? 2'b10 : 2'b01));
            if (grant_id) req_read = 2'b01;
            tick();
        end
        check("t6 order", LW'(order), LW'(3'b010));
        req_read = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
